// File: rtl/inst_rom_pkg.sv
// Shared types and constants for the instruction-memory responder.
package inst_rom_pkg;

  localparam int          INST_BUS_W   = 32;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic        CHIP_ENABLE  = 1'b1;
  localparam logic        CHIP_DISABLE = 1'b0;
  localparam logic        RST_ENABLE   = 1'b0;

  typedef enum logic [1:0] {
    IROM_IDLE = 2'd0,
    IROM_WAIT = 2'd1,
    IROM_RESP = 2'd2
  } irom_state_e;

  typedef struct packed {
    logic misaligned;
    logic addr_err;
  } fetch_err_t;

endpackage

// File: rtl/inst_mem_array.sv
// Synchronous instruction store: one read port, one write port, read-before-write.
module inst_mem_array
  import inst_rom_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [INST_BUS_W-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [INST_BUS_W-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [INST_BUS_W-1:0] mem_q [DEPTH];

  // NOTE: the store has no reset so it maps onto block RAM; the non-blocking
  // write lets a same-edge read of that word see the old contents.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/inst_rom.sv
// Fetch responder: captures pc/ce, adds wait states, returns one instruction per fetch.
module inst_rom
  import inst_rom_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [31:0]           pc,
  output logic [INST_BUS_W-1:0] inst,
  output logic                  inst_valid,
  output logic                  stall,
  output logic                  misaligned,
  output logic                  addr_err,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [INST_BUS_W-1:0] ld_data
);

  if (WAIT_STATES < 0 || WAIT_STATES > 7) begin : g_bad_wait_states
    $error("inst_rom: WAIT_STATES must be 0..7");
  end

  localparam logic [2:0] WAIT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  irom_state_e           state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  fetch_err_t            err_q, err_d;
  logic                  accept;
  logic [INST_BUS_W-1:0] rdata;

  logic [DEPTH_LOG2-1:0] word_idx;
  fetch_err_t            pc_err;

  assign word_idx          = pc[DEPTH_LOG2+1:2];
  assign pc_err.misaligned = |pc[1:0];
  assign pc_err.addr_err   = |pc[31:DEPTH_LOG2+2];

  inst_mem_array #(.ADDR_W(DEPTH_LOG2)) u_mem (
    .clk     (clk),
    .we_i    (ld_en),
    .waddr_i (ld_addr),
    .wdata_i (ld_data),
    .re_i    (accept),
    .raddr_i (word_idx),
    .rdata_o (rdata)
  );

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    accept  = 1'b0;
    unique case (state_q)
      IROM_IDLE: accept = (ce == CHIP_ENABLE);
      IROM_WAIT: begin
        if (ce == CHIP_DISABLE)  state_d = IROM_IDLE;
        else if (cnt_q == 3'd0)  state_d = IROM_RESP;
        else                     cnt_d   = cnt_q - 3'd1;
      end
      IROM_RESP: begin
        accept  = (ce == CHIP_ENABLE);
        state_d = IROM_IDLE;
      end
      default: state_d = IROM_IDLE;
    endcase
    // A capture is shared by IDLE and back-to-back RESP.
    if (accept) begin
      err_d   = pc_err;
      cnt_d   = WAIT_INIT;
      state_d = (WAIT_STATES == 0) ? IROM_RESP : IROM_WAIT;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q <= IROM_IDLE;
      cnt_q   <= 3'd0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode from registered state so a reset zeroes them at once.
  assign inst_valid = (state_q == IROM_RESP);
  assign stall      = (state_q == IROM_WAIT);
  assign misaligned = inst_valid && err_q.misaligned;
  assign addr_err   = inst_valid && err_q.addr_err;
  assign inst       = (inst_valid && !err_q.misaligned && !err_q.addr_err) ? rdata : ZERO_WORD;

endmodule

// File: tb/tb_inst_rom.sv
// Directed bench for inst_rom: three instances cover WAIT_STATES = 0, 2 and 3.
module tb_inst_rom;

  logic        clk;
  logic        rst;
  logic        ce0, ce2, ce3;
  logic [31:0] pc;
  logic        ld_en;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;

  logic [31:0] inst0, inst2, inst3;
  logic        v0, v2, v3, st0, st2, st3, mis0, mis2, mis3, err0, err2, err3;
  logic [35:0] out0, out2, out3;

  int n_tests = 0;
  int n_fail  = 0;

  inst_rom #(.DEPTH_LOG2(10), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .ce(ce0), .pc(pc), .inst(inst0), .inst_valid(v0),
    .stall(st0), .misaligned(mis0), .addr_err(err0),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

  inst_rom #(.DEPTH_LOG2(10), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .rst(rst), .ce(ce2), .pc(pc), .inst(inst2), .inst_valid(v2),
    .stall(st2), .misaligned(mis2), .addr_err(err2),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

  inst_rom #(.DEPTH_LOG2(10), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst), .ce(ce3), .pc(pc), .inst(inst3), .inst_valid(v3),
    .stall(st3), .misaligned(mis3), .addr_err(err3),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

  assign out0 = {v0, st0, mis0, err0, inst0};
  assign out2 = {v2, st2, mis2, err2, inst2};
  assign out3 = {v3, st3, mis3, err3, inst3};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ce;
    logic [31:0] pc;
    logic [35:0] exp;
  } vec_t;

  function automatic logic [35:0] eo(input logic v, input logic s, input logic m,
                                     input logic e, input logic [31:0] i);
    return {v, s, m, e, i};
  endfunction

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got valid=%0b stall=%0b mis=%0b err=%0b inst=%h, want valid=%0b stall=%0b mis=%0b err=%0b inst=%h",
               name, act[35], act[34], act[33], act[32], act[31:0],
               exp[35], exp[34], exp[33], exp[32], exp[31:0]);
    end
  endtask

  // Inputs are already driven; sample mid-cycle, then move to just past the next edge.
  task automatic cyc(input string name, input int sel, input logic [35:0] exp);
    @(negedge clk);
    case (sel)
      0:       check(name, out0, exp);
      2:       check(name, out2, exp);
      default: check(name, out3, exp);
    endcase
    @(posedge clk);
    #1;
  endtask

  logic [31:0] prog [4];
  vec_t        vecs [10];

  initial begin
    prog = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00308193};
    vecs[0] = '{1'b1, 32'h0000_0000, eo(0, 0, 0, 0, 32'h0)};
    vecs[1] = '{1'b1, 32'h0000_0004, eo(1, 0, 0, 0, 32'h00000013)};
    vecs[2] = '{1'b1, 32'h0000_0008, eo(1, 0, 0, 0, 32'h00100093)};
    vecs[3] = '{1'b1, 32'h0000_000C, eo(1, 0, 0, 0, 32'h00200113)};
    vecs[4] = '{1'b1, 32'h0000_0006, eo(1, 0, 0, 0, 32'h00308193)};
    vecs[5] = '{1'b1, 32'h0000_1000, eo(1, 0, 1, 0, 32'h0)};
    vecs[6] = '{1'b1, 32'h0000_1002, eo(1, 0, 0, 1, 32'h0)};
    vecs[7] = '{1'b0, 32'h0000_0000, eo(1, 0, 1, 1, 32'h0)};
    vecs[8] = '{1'b0, 32'h0000_0000, eo(0, 0, 0, 0, 32'h0)};
    vecs[9] = '{1'b0, 32'h0000_0000, eo(0, 0, 0, 0, 32'h0)};

    rst = 1'b0; ce0 = 1'b0; ce2 = 1'b0; ce3 = 1'b0;
    pc = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (2) @(posedge clk);
    #1;

    // Preload under reset: the loader works in any state.
    for (int i = 0; i < 4; i++) begin
      ld_en = 1'b1; ld_addr = 10'(i); ld_data = prog[i];
      @(posedge clk);
      #1;
    end
    ld_en = 1'b0;

    @(negedge clk);
    check("reset_ws0", out0, '0);
    check("reset_ws2", out2, '0);
    check("reset_ws3", out3, '0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Back-to-back fetches with zero wait states, including error pcs.
    for (int i = 0; i < 10; i++) begin
      ce0 = vecs[i].ce;
      pc  = vecs[i].pc;
      cyc($sformatf("ws0_vec%0d", i), 0, vecs[i].exp);
    end

    // Same-edge load and fetch of word 2 returns the old word first.
    ld_en = 1'b1; ld_addr = 10'd2; ld_data = 32'hDEADBEEF; ce0 = 1'b1; pc = 32'h8;
    cyc("collide_issue", 0, eo(0, 0, 0, 0, 32'h0));
    ld_en = 1'b0;
    cyc("collide_old", 0, eo(1, 0, 0, 0, 32'h00200113));
    ce0 = 1'b0;
    cyc("collide_new", 0, eo(1, 0, 0, 0, 32'hDEADBEEF));
    cyc("collide_idle", 0, eo(0, 0, 0, 0, 32'h0));

    // Two wait states, then a second fetch issued during the response cycle.
    ce2 = 1'b1; pc = 32'h4;
    cyc("ws2_issue",  2, eo(0, 0, 0, 0, 32'h0));
    cyc("ws2_wait1",  2, eo(0, 1, 0, 0, 32'h0));
    cyc("ws2_wait2",  2, eo(0, 1, 0, 0, 32'h0));
    pc = 32'hC;
    cyc("ws2_resp",   2, eo(1, 0, 0, 0, 32'h00100093));
    cyc("ws2_b_wait1", 2, eo(0, 1, 0, 0, 32'h0));
    cyc("ws2_b_wait2", 2, eo(0, 1, 0, 0, 32'h0));
    ce2 = 1'b0;
    cyc("ws2_b_resp", 2, eo(1, 0, 0, 0, 32'h00308193));
    cyc("ws2_idle",   2, eo(0, 0, 0, 0, 32'h0));

    // Asynchronous reset in the middle of a wait.
    ce3 = 1'b1; pc = 32'h0;
    cyc("ws3_issue", 3, eo(0, 0, 0, 0, 32'h0));
    cyc("ws3_wait1", 3, eo(0, 1, 0, 0, 32'h0));
    #2;
    rst = 1'b0;
    #1;
    check("ws3_async_rst", out3, '0);
    ce3 = 1'b0;
    @(posedge clk);
    #1;
    check("ws3_rst_held", out3, '0);
    rst = 1'b1;

    // Dropping ce mid-wait aborts without a response.
    ce3 = 1'b1; pc = 32'h4;
    cyc("ws3_ab_issue", 3, eo(0, 0, 0, 0, 32'h0));
    cyc("ws3_ab_wait1", 3, eo(0, 1, 0, 0, 32'h0));
    ce3 = 1'b0;
    cyc("ws3_ab_drop",  3, eo(0, 1, 0, 0, 32'h0));
    cyc("ws3_ab_idle1", 3, eo(0, 0, 0, 0, 32'h0));
    cyc("ws3_ab_idle2", 3, eo(0, 0, 0, 0, 32'h0));

    // A full fetch afterwards uses all three wait states.
    ce3 = 1'b1; pc = 32'h8;
    cyc("ws3_f_issue", 3, eo(0, 0, 0, 0, 32'h0));
    cyc("ws3_f_wait1", 3, eo(0, 1, 0, 0, 32'h0));
    cyc("ws3_f_wait2", 3, eo(0, 1, 0, 0, 32'h0));
    cyc("ws3_f_wait3", 3, eo(0, 1, 0, 0, 32'h0));
    ce3 = 1'b0;
    cyc("ws3_f_resp",  3, eo(1, 0, 0, 0, 32'hDEADBEEF));
    cyc("ws3_f_idle",  3, eo(0, 0, 0, 0, 32'h0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
